// File: rtl/synth_pkg.sv
// Shared synth definitions: voice-scan FSM encoding and default table geometry
// (also used by the phase RAM instance).
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } seq_state_t;

  localparam int VOICE_BITS_DEF  = 5;
  localparam int PHASE_WIDTH_DEF = 24;

endpackage

// File: rtl/voice_phase_sequencer_phase_adder.sv
// Phase update for one voice: zero-extended tuning-word add with gate masking,
// plus the registered output stage presented to the oscillator.
module phase_adder #(
  parameter int PHASE_WIDTH = 24,
  parameter int TW_WIDTH    = 24,
  parameter int VOICE_BITS  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   gate,
  input  logic                   last,
  input  logic [VOICE_BITS-1:0]  voice,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  input  logic [TW_WIDTH-1:0]    tw_in,
  output logic [PHASE_WIDTH-1:0] sum,
  output logic                   phase_valid,
  output logic [VOICE_BITS-1:0]  phase_voice,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic                   scan_done
);

  logic [PHASE_WIDTH-1:0] raw;

  // Carry out of the top bit is dropped, so the phase wraps naturally.
  always_comb begin
    raw = phase_in + PHASE_WIDTH'(tw_in);
    sum = '0;
    if (load && gate) sum = raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_valid <= 1'b0;
      phase_voice <= '0;
      phase_out   <= '0;
      scan_done   <= 1'b0;
    end else begin
      phase_valid <= load;
      scan_done   <= load && last;
      if (load) begin
        phase_voice <= voice;
        phase_out   <= sum;
      end
    end
  end

endmodule

// File: rtl/voice_phase_sequencer.sv
// Per-sample voice scan: read-modify-write of every voice phase in the phase RAM.
// Optional per-voice gating with gate_mask is enabled by defining VOICE_GATE_EN.
module voice_phase_sequencer
  import synth_pkg::*;
#(
  parameter int VOICE_BITS  = VOICE_BITS_DEF,
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int TW_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  output logic [VOICE_BITS-1:0]   ram_addr,
  output logic                    ram_we,
  output logic [PHASE_WIDTH-1:0]  ram_din,
  input  logic [PHASE_WIDTH-1:0]  ram_dout,
  output logic [VOICE_BITS-1:0]   tw_addr,
  input  logic [TW_WIDTH-1:0]     tw_data,
`ifdef VOICE_GATE_EN
  input  logic [2**VOICE_BITS-1:0] gate_mask,
`endif
  output logic                    phase_valid,
  output logic [VOICE_BITS-1:0]   phase_voice,
  output logic [PHASE_WIDTH-1:0]  phase_out,
  output logic                    busy,
  output logic                    scan_done,
  output logic                    overrun
);

  localparam int NUM_VOICES = 2**VOICE_BITS;
  localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES - 1);

  seq_state_t            state;
  logic [VOICE_BITS-1:0] v;
  logic                  gate;
  logic                  in_wr;
  logic                  last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      v       <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= sample_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= RD;
            v     <= '0;
          end
        end
        RD: state <= WR;
        WR: begin
          if (v == LAST_VOICE) begin
            state <= IDLE;
          end else begin
            v     <= v + 1'b1;
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign in_wr    = (state == WR);
  assign last     = (v == LAST_VOICE);
  assign ram_we   = in_wr;
  assign ram_addr = busy ? v : '0;
  assign tw_addr  = busy ? v : '0;

`ifdef VOICE_GATE_EN
  assign gate = gate_mask[v];
`else
  assign gate = 1'b1;
`endif

  phase_adder #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .TW_WIDTH    (TW_WIDTH),
    .VOICE_BITS  (VOICE_BITS)
  ) u_adder (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (in_wr),
    .gate        (gate),
    .last        (last),
    .voice       (v),
    .phase_in    (ram_dout),
    .tw_in       (tw_data),
    .sum         (ram_din),
    .phase_valid (phase_valid),
    .phase_voice (phase_voice),
    .phase_out   (phase_out),
    .scan_done   (scan_done)
  );

endmodule

// File: tb/tb_voice_phase_sequencer.sv
// Directed bench for voice_phase_sequencer with behavioural phase RAM and
// tuning-word table; a second small instance covers the narrow tuning word.
`timescale 1ns/1ps
module tb_voice_phase_sequencer;
  import synth_pkg::*;

  localparam int VB  = VOICE_BITS_DEF;
  localparam int PW  = PHASE_WIDTH_DEF;
  localparam int NV  = 2**VB;
  localparam int VB2 = 2;
  localparam int NV2 = 4;
  localparam int TW2 = 16;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sample_tick;
  logic [VB-1:0] ram_addr, tw_addr, phase_voice;
  logic          ram_we, phase_valid, busy, scan_done, overrun;
  logic [PW-1:0] ram_din, ram_dout, phase_out, tw_data;
`ifdef VOICE_GATE_EN
  logic [NV-1:0]  gate_mask;
  logic [NV2-1:0] gate_mask2;
`endif

  logic          mem_clr, bk_we;
  logic [VB-1:0] bk_addr;
  logic [PW-1:0] bk_data;
  logic [PW-1:0] mem [NV];
  logic [PW-1:0] twm [NV];

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < NV; i++) mem[i] <= '0;
    else if (bk_we) mem[bk_addr] <= bk_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    tw_data  <= twm[tw_addr];
  end

  voice_phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .tw_addr(tw_addr), .tw_data(tw_data),
`ifdef VOICE_GATE_EN
    .gate_mask(gate_mask),
`endif
    .phase_valid(phase_valid), .phase_voice(phase_voice), .phase_out(phase_out),
    .busy(busy), .scan_done(scan_done), .overrun(overrun)
  );

  logic           tick2, we2, valid2, busy2, done2, ovr2, mem2_clr;
  logic [VB2-1:0] ram_addr2, tw_addr2, voice2;
  logic [PW-1:0]  din2, dout2, out2;
  logic [TW2-1:0] tw2;
  logic [PW-1:0]  mem2 [NV2];

  always @(posedge clk) begin
    if (mem2_clr) for (int i = 0; i < NV2; i++) mem2[i] <= 24'h00FFFF;
    else if (we2) mem2[ram_addr2] <= din2;
    dout2 <= mem2[ram_addr2];
    tw2   <= (tw_addr2 == tw_addr2) ? 16'hFFFF : 16'h0000;
  end

  voice_phase_sequencer #(.VOICE_BITS(VB2), .PHASE_WIDTH(PW), .TW_WIDTH(TW2)) dut16 (
    .clk(clk), .rst_n(rst_n), .sample_tick(tick2),
    .ram_addr(ram_addr2), .ram_we(we2), .ram_din(din2), .ram_dout(dout2),
    .tw_addr(tw_addr2), .tw_data(tw2),
`ifdef VOICE_GATE_EN
    .gate_mask(gate_mask2),
`endif
    .phase_valid(valid2), .phase_voice(voice2), .phase_out(out2),
    .busy(busy2), .scan_done(done2), .overrun(ovr2)
  );

  task automatic clear_mem();
    @(posedge clk); #1 mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
  endtask

  task automatic poke(input logic [VB-1:0] a, input logic [PW-1:0] d);
    @(posedge clk); #1 bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(posedge clk); #1 bk_we = 1'b0;
  endtask

  task automatic fill_tw(input logic [PW-1:0] d);
    for (int i = 0; i < NV; i++) twm[i] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_addr, ram_we, ram_din, tw_addr, phase_valid, phase_voice, phase_out,
         busy, scan_done, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0h din=%0h valid=%b busy=%b done=%b ovr=%b, expected all 0",
               ram_we, ram_addr, ram_din, phase_valid, busy, scan_done, overrun);
    end
    n_cmp++;
    if ({valid2, busy2, we2, out2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs16: got valid=%b busy=%b we=%b out=%0h, expected 0", valid2, busy2, we2, out2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_full_scan();
    logic eb, ev, ed, ew;
    fill_tw(24'd1);
    clear_mem();
    @(posedge clk); #1 sample_tick = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      @(posedge clk); #1;
      if (c == 1) sample_tick = 1'b0;
      eb = (c <= 64);
      ev = (c >= 3) && (c <= 65) && (c % 2 == 1);
      ed = (c == 65);
      ew = (c >= 2) && (c <= 64) && (c % 2 == 0);
      n_cmp++;
      if ({busy, phase_valid, scan_done, ram_we, overrun} !== {eb, ev, ed, ew, 1'b0}) begin
        n_bad++;
        $display("FAIL full_ctrl c=%0d: got busy/valid/done/we/ovr=%b%b%b%b%b expected %b%b%b%b0",
                 c, busy, phase_valid, scan_done, ram_we, overrun, eb, ev, ed, ew);
      end
      if (ev) begin
        n_cmp++;
        if (phase_voice !== VB'((c - 3) / 2) || phase_out !== 24'd1) begin
          n_bad++;
          $display("FAIL full_out c=%0d: got voice=%0d out=%0h expected voice=%0d out=1",
                   c, phase_voice, phase_out, (c - 3) / 2);
        end
      end
      if (eb) begin
        n_cmp++;
        if (ram_addr !== VB'((c - 1) / 2) || tw_addr !== VB'((c - 1) / 2)) begin
          n_bad++;
          $display("FAIL full_addr c=%0d: got ram=%0d tw=%0d expected %0d", c, ram_addr, tw_addr, (c - 1) / 2);
        end
      end
    end
    for (int i = 0; i < NV; i++) begin
      n_cmp++;
      if (mem[i] !== 24'd1) begin
        n_bad++;
        $display("FAIL full_ram[%0d]: got %0h expected 1", i, mem[i]);
      end
    end
  endtask

  task automatic test_wrap();
    fill_tw(24'd1);
    twm[3] = 24'h000020;
    clear_mem();
    poke(5'd3, 24'hFFFFF0);
    @(posedge clk); #1 sample_tick = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      @(posedge clk); #1;
      if (c == 1) sample_tick = 1'b0;
      if (c == 8) begin
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 5'd3 || ram_din !== 24'h000010) begin
          n_bad++;
          $display("FAIL wrap_din: got we=%b addr=%0d din=%0h expected 1/3/10", ram_we, ram_addr, ram_din);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (phase_valid !== 1'b1 || phase_voice !== 5'd3 || phase_out !== 24'h000010) begin
          n_bad++;
          $display("FAIL wrap_out: got valid=%b voice=%0d out=%0h expected 1/3/10", phase_valid, phase_voice, phase_out);
        end
      end
    end
    n_cmp++;
    if (mem[3] !== 24'h000010 || mem[2] !== 24'd1) begin
      n_bad++;
      $display("FAIL wrap_ram: got ram3=%0h ram2=%0h expected 10/1", mem[3], mem[2]);
    end
  endtask

  task automatic test_overrun_back_to_back();
    int nvalid = 0;
    fill_tw(24'd1);
    clear_mem();
    @(posedge clk); #1 sample_tick = 1'b1;
    for (int c = 1; c <= 132; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (overrun !== (c == 11)) begin
        n_bad++;
        $display("FAIL overrun c=%0d: got %b expected %b", c, overrun, (c == 11));
      end
      if (c <= 65 && phase_valid === 1'b1) nvalid++;
      if (c == 65) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_busy_fall: got busy=%b expected 0", busy);
        end
      end
      if (c == 66) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_restart: got busy=%b expected 1", busy);
        end
      end
      if (c == 130) begin
        n_cmp++;
        if (scan_done !== 1'b1 || phase_voice !== 5'd31) begin
          n_bad++;
          $display("FAIL b2b_done: got done=%b voice=%0d expected 1/31", scan_done, phase_voice);
        end
      end
      sample_tick = (c == 10) || (c == 65);
    end
    n_cmp++;
    if (nvalid != 32) begin
      n_bad++;
      $display("FAIL overrun_count: got %0d outputs expected 32", nvalid);
    end
    n_cmp++;
    if (mem[0] !== 24'd2 || mem[31] !== 24'd2) begin
      n_bad++;
      $display("FAIL b2b_ram: got ram0=%0h ram31=%0h expected 2/2", mem[0], mem[31]);
    end
  endtask

  task automatic test_reset_mid_scan();
    fill_tw(24'd1);
    clear_mem();
    @(posedge clk); #1 sample_tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) sample_tick = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ram_addr, ram_we, ram_din, tw_addr, phase_valid, phase_voice, phase_out,
         busy, scan_done, overrun} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got we=%b addr=%0h din=%0h valid=%b busy=%b, expected all 0",
               ram_we, ram_addr, ram_din, phase_valid, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || phase_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_noresume: got busy=%b valid=%b expected 0/0", busy, phase_valid);
    end
    for (int i = 0; i < NV; i++) begin
      n_cmp++;
      if (mem[i] !== ((i < 5) ? 24'd1 : 24'd0)) begin
        n_bad++;
        $display("FAIL midreset_ram[%0d]: got %0h expected %0h", i, mem[i], (i < 5) ? 1 : 0);
      end
    end
  endtask

`ifdef VOICE_GATE_EN
  task automatic test_gate();
    fill_tw(24'd1);
    gate_mask = 32'hFFFF_FFFE;
    clear_mem();
    poke(5'd0, 24'h123456);
    @(posedge clk); #1 sample_tick = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      @(posedge clk); #1;
      if (c == 1) sample_tick = 1'b0;
      if (c == 3 || c == 5) begin
        n_cmp++;
        if (phase_valid !== 1'b1 || phase_out !== ((c == 3) ? 24'd0 : 24'd1)) begin
          n_bad++;
          $display("FAIL gate_out c=%0d: got valid=%b out=%0h expected 1/%0d", c, phase_valid, phase_out, (c == 3) ? 0 : 1);
        end
      end
    end
    n_cmp++;
    if (mem[0] !== 24'd0 || mem[1] !== 24'd1) begin
      n_bad++;
      $display("FAIL gate_ram: got ram0=%0h ram1=%0h expected 0/1", mem[0], mem[1]);
    end
    gate_mask = '1;
  endtask
`endif

  task automatic test_tw16_zero_extend();
    @(posedge clk); #1 mem2_clr = 1'b1;
    @(posedge clk); #1 mem2_clr = 1'b0;
    @(posedge clk); #1 tick2 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) tick2 = 1'b0;
      if (c == 3 || c == 5 || c == 7 || c == 9) begin
        n_cmp++;
        if (valid2 !== 1'b1 || voice2 !== VB2'((c - 3) / 2) || out2 !== 24'h01FFFE || done2 !== (c == 9)) begin
          n_bad++;
          $display("FAIL tw16_out c=%0d: got valid=%b voice=%0d out=%0h done=%b expected 1/%0d/1fffe/%b",
                   c, valid2, voice2, out2, done2, (c - 3) / 2, (c == 9));
        end
      end
    end
    for (int i = 0; i < NV2; i++) begin
      n_cmp++;
      if (mem2[i] !== 24'h01FFFE) begin
        n_bad++;
        $display("FAIL tw16_ram[%0d]: got %0h expected 1fffe", i, mem2[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; tick2 = 1'b0;
    mem_clr = 1'b0; mem2_clr = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
`ifdef VOICE_GATE_EN
    gate_mask = '1; gate_mask2 = '1;
`endif
    fill_tw(24'd1);
    test_reset();
    test_full_scan();
    test_wrap();
    test_overrun_back_to_back();
    test_reset_mid_scan();
`ifdef VOICE_GATE_EN
    test_gate();
`endif
    test_tw16_zero_extend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
